// File: rtl/psum_pkg.sv
// Shared definitions for the psum output drain: default geometry, word type and drain FSM states.
package psum_pkg;

    localparam int COL     = 8;
    localparam int BW_PSUM = 19;
    localparam int NW      = 2 * COL;

    typedef logic signed [BW_PSUM-1:0] psum_word_t;

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

endpackage

// File: rtl/vec_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with a combinational head and occupancy count.
module vec_fifo #(
    parameter int WIDTH = 304,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Buffers whole psum vectors and serializes them one word per cycle with valid/ready and a last flag.
// Build option: define PSUM_DRAIN_RELU_EN to clamp negative output words to zero.
module psum_drain
    import psum_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw_psum = 19,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2*col*bw_psum-1:0]    in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [bw_psum-1:0]          out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(2*col)-1:0]    out_idx,
    output logic [$clog2(DEPTH):0]      vec_count,
    output logic                        fsm_state
);

    localparam int NWORDS = 2 * col;
    localparam int IW     = $clog2(NWORDS);
    localparam int VW     = NWORDS * bw_psum;
    localparam int CW     = $clog2(DEPTH) + 1;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid
    // and ready are both high; a held valid keeps its data stable until accepted.
    drain_state_e         state;
    drain_state_e         state_next;
    logic [IW-1:0]        idx;
    logic [VW-1:0]        head;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 push;
    logic                 accept;
    logic                 last_word;
    logic                 pop;
    logic [bw_psum-1:0]   raw_word;

    vec_fifo #(
        .WIDTH (VW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .full    (full)
    );

    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign accept    = (state == STREAM) && out_ready;
    assign last_word = (idx == IW'(NWORDS - 1));
    assign pop       = accept && last_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx <= last_word ? '0 : idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (push) state_next = STREAM;
            STREAM:  if (pop && !push && (count == CW'(1))) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign raw_word = head[idx*bw_psum +: bw_psum];

    always_comb begin
        out_data = '0;
        if (state == STREAM) begin
`ifdef PSUM_DRAIN_RELU_EN
            out_data = raw_word[bw_psum-1] ? '0 : raw_word;
`else
            out_data = raw_word;
`endif
        end
    end

    assign out_valid = (state == STREAM);
    assign out_last  = out_valid && last_word;
    assign out_idx   = idx;
    assign vec_count = count;
    assign fsm_state = state;

endmodule

// File: tb/tb_psum_drain.sv
// Directed-plus-random bench for psum_drain checked against a vector-queue reference model.
module tb_psum_drain;
    import psum_pkg::*;

    localparam int COLS  = 8;
    localparam int BW    = 19;
    localparam int DEPTH = 4;
    localparam int NWV   = 2 * COLS;
    localparam int VW    = NWV * BW;

    logic            clk = 1'b0;
    logic            reset;
    logic [VW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [BW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [3:0]      out_idx;
    logic [2:0]      vec_count;
    logic            fsm_state;

    logic [VW-1:0]   mq[$];
    int              m_idx;
    logic [BW-1:0]   exp_q[$];
    int              checks = 0;
    int              errors = 0;

    psum_drain #(.col(COLS), .bw_psum(BW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .vec_count (vec_count),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] ref_word(input logic [VW-1:0] v, input int k);
        logic [BW-1:0] w;
        w = v[k*BW +: BW];
`ifdef PSUM_DRAIN_RELU_EN
        if (w[BW-1]) w = '0;
`endif
        return w;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < NWV; k++) v[k*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit has;
        has = (mq.size() > 0);
        check("out_valid", 64'(out_valid), 64'(has));
        check("fsm_state", 64'(fsm_state), 64'(has));
        check("out_data", 64'(out_data), has ? 64'(ref_word(mq[0], m_idx)) : 64'd0);
        check("out_idx", 64'(out_idx), has ? 64'(m_idx) : 64'd0);
        check("out_last", 64'(out_last), 64'(has && (m_idx == NWV - 1)));
        check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        check("vec_count", 64'(vec_count), 64'(mq.size()));
        if (out_valid && out_ready) begin
            check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("sb_word", 64'(out_data), 64'(exp_q.pop_front()));
        end
    endtask

    // Entered and left at posedge+1: drive, check at negedge, advance model at the edge.
    task automatic step(input logic v, input logic [VW-1:0] d, input logic r, output bit pushed);
        bit accepted;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        check_outputs();
        pushed   = v && (mq.size() < DEPTH);
        accepted = (mq.size() > 0) && r;
        @(posedge clk);
        if (accepted) begin
            if (m_idx == NWV - 1) begin
                void'(mq.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (pushed) begin
            mq.push_back(d);
            for (int k = 0; k < NWV; k++) exp_q.push_back(ref_word(d, k));
        end
        #1;
    endtask

    task automatic drain(input int budget);
        bit p;
        int n;
        n = 0;
        while (mq.size() > 0 && n < budget) begin
            step(1'b0, '0, 1'b1, p);
            n++;
        end
        check("drain_done", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        logic [VW-1:0] v;
        bit p;
        int n;
        int pushes;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        m_idx = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_vec_count", 64'(vec_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Single vector with word k = k+1, full-rate drain.
        for (int k = 0; k < NWV; k++) v[k*BW +: BW] = BW'(k + 1);
        step(1'b1, v, 1'b1, p);
        check("t1_first_word", 64'(out_data), 64'd1);
        for (int i = 0; i < NWV + 1; i++) step(1'b0, '0, 1'b1, p);
        check("t1_empty", 64'(vec_count), 64'd0);

        // Five back-to-back pushes against a stalled sink.
        for (int i = 0; i < 4; i++) step(1'b1, rand_vec(), 1'b0, p);
        v = rand_vec();
        for (int i = 0; i < 3; i++) step(1'b1, v, 1'b0, p);
        check("t2_full_count", 64'(vec_count), 64'd4);
        p = 1'b0; n = 0;
        while (!p && n < 40) begin
            step(1'b1, v, 1'b1, p);
            n++;
        end
        check("t2_fifth_taken", 64'(p), 64'd1);
        drain(200);

        // Sink toggling ready every cycle.
        step(1'b1, rand_vec(), 1'b1, p);
        n = 0;
        while (mq.size() > 0 && n < 60) begin
            step(1'b0, '0, n[0], p);
            n++;
        end
        check("t3_done", 64'(mq.size()), 64'd0);

        // Eight vectors at full rate on both sides; pointers wrap twice.
        pushes = 0; n = 0; v = rand_vec();
        while ((pushes < 8 || mq.size() > 0) && n < 400) begin
            step(pushes < 8, v, 1'b1, p);
            if (p) begin
                pushes++;
                v = rand_vec();
            end
            n++;
        end
        check("t4_pushes", 64'(pushes), 64'd8);

        // Random traffic on both handshakes.
        for (int i = 0; i < 150; i++) step(1'($urandom_range(0, 1)), rand_vec(), 1'($urandom_range(0, 1)), p);
        drain(200);

        // Reset in the middle of the second of three queued vectors.
        for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 1'b0, p);
        for (int i = 0; i < NWV + 7; i++) step(1'b0, '0, 1'b1, p);
        check("t5_pre_idx", 64'(out_idx), 64'd7);
        reset = 1'b0;
        #1;
        mq.delete(); exp_q.delete(); m_idx = 0;
        check("t5_rst_valid", 64'(out_valid), 64'd0);
        check("t5_rst_count", 64'(vec_count), 64'd0);
        check("t5_rst_idx", 64'(out_idx), 64'd0);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        step(1'b1, rand_vec(), 1'b1, p);
        check("t5_restart_idx", 64'(out_idx), 64'd0);
        drain(40);

        // Sign pattern: alternating -1 and +5.
        for (int k = 0; k < NWV; k++) v[k*BW +: BW] = (k % 2 == 0) ? 19'h7FFFF : 19'h00005;
        step(1'b1, v, 1'b1, p);
`ifdef PSUM_DRAIN_RELU_EN
        check("t6_neg_word", 64'(out_data), 64'd0);
`else
        check("t6_neg_word", 64'(out_data), 64'h7FFFF);
`endif
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Downstream output stage of the two-core attention array.
- Consumes the concatenated psum vector {core1 out, core0 out}, 2*col*bw_psum bits per vector, through a valid/ready handshake.
- Buffers up to DEPTH vectors in a FIFO, then serializes each vector into one bw_psum word per cycle toward the host/testbench, with valid/ready and a last-word flag.
- Decouples core output timing from a narrow, stallable output port.

Parameters:
- col, 8, columns per core
- bw_psum, 19, width of one psum word (2*bw+3 with bw=8)
- DEPTH, 4, FIFO depth in whole vectors; power of 2, >=2
- NW, 2*col (derived localparam, not overridable), words per vector

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- in_data  input  2*col*bw_psum  psum vector; word k = in_data[(k+1)*bw_psum-1 : k*bw_psum]
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  FIFO can accept a vector
- out_data  output  bw_psum  current serialized word
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts out_data
- out_last  output  1  out_data is word NW-1 of its vector
- out_idx  output  $clog2(NW)  index of the current word in its vector
- vec_count  output  $clog2(DEPTH)+1  vectors held, including a partially drained head

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr, count and word index clear to 0.
  - FSM enters EMPTY.
  - out_valid=0, out_last=0, out_idx=0, out_data=0, vec_count=0, in_ready=1.
  - FIFO storage is not cleared.
- Push: when in_valid && in_ready at a rising edge, the vector is written at wr_ptr, wr_ptr advances modulo DEPTH, and count increments.
- in_ready = (count != DEPTH), derived combinationally from registered count only.
  - No same-cycle bypass: when full, in_ready=0 even if a pop happens in the same cycle.
- in_valid while in_ready=0 is legal; the source holds the vector and nothing is lost.
- FSM has two states:
  - EMPTY: count==0; out_valid=0; out_data=0.
  - STREAM: count>0; out_valid=1; out_data = word[idx] of the head vector at rd_ptr.
- Transitions:
  - EMPTY->STREAM on the edge that pushes into an empty FIFO. First out_valid appears the cycle after the push edge (1-cycle latency).
  - STREAM->EMPTY when the last word of the final held vector is accepted and no push occurs in the same cycle.
- Word accept (out_valid && out_ready):
  - idx < NW-1: idx increments.
  - idx == NW-1: idx returns to 0, rd_ptr advances modulo DEPTH, count decrements (pop).
- Simultaneous push and pop: count unchanged; FSM stays in STREAM.
- While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- out_last = out_valid && (idx == NW-1).
- Throughput: one word per cycle when out_ready is held high; back-to-back vectors with no bubble.
- Pointer wrap: pointers carry no extra bit; full/empty is decided solely by count.
- Reset asserted mid-vector: the partial vector and all queued vectors are discarded. After reset release, the next push starts streaming at idx 0.
- vec_count = count.

Optional Feature:
- Macro: PSUM_DRAIN_RELU_EN.
  - Defined: each word is passed through ReLU on output. If the word's MSB (sign) is 1, out_data=0; otherwise out_data is the word unchanged. Stored data is unmodified.
  - Undefined: out_data is the raw signed word.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package psum_pkg holds the localparams BW_PSUM and NW, a typedef psum_word_t (logic signed [bw_psum-1:0]), and the FSM state enum {EMPTY, STREAM}.
- One sub-module, vec_fifo: a generic DEPTH x WIDTH synchronous FIFO exposing count.
- psum_drain contains vec_fifo, the word-index counter, the output mux, and the ReLU logic.

Test Plan:
- Single vector, word k = k+1, out_ready=1 → words 1..16 on 16 consecutive cycles starting the cycle after the push; out_last only on word 16; vec_count goes 1→0.
- Push 5 vectors back-to-back with out_ready=0 → 4 vectors accepted; in_ready=0 on the 5th until the first vector fully drains; vec_count=4; no data loss, order preserved.
- out_ready toggling 1,0,1,0 during a vector → out_data and out_idx stable on stall cycles; all 16 words delivered exactly once.
- Continuous push and drain at full rate over 8 vectors (pointer wrap twice) → no bubble between word 15 of one vector and word 0 of the next; data matches a scoreboard.
- reset pulsed low at idx=7 of vector 2 with 3 vectors queued → out_valid=0 and vec_count=0 immediately; the next pushed vector streams from idx 0.
- PSUM_DRAIN_RELU_EN defined, words alternating 19'h7FFFF (-1) and 19'h00005 → outputs alternate 0 and 5; undefined build → 0x7FFFF and 5.
